// File: rtl/key_step_conditioner.sv
// key_step_conditioner
//   Front end for the sequence-detector FSM. Synchronizes and debounces the
//   raw active-low step pushbutton, synchronizes the raw data switch, and
//   emits one clean single-cycle step pulse per physical press together with
//   the data bit sampled on that press. The detector advances on step and
//   consumes w_out, so it never clocks off the bouncing key directly.
//
// Ports
//   clock       in   1            system clock, rising edge
//   reset       in   1            asynchronous, active-high reset
//   key_n       in   1            raw pushbutton, low = pressed, async to clock
//   sw_w        in   1            raw data switch, async to clock
//   step        out  1            one-cycle pulse per accepted press
//   w_out       out  1            w sampled on the step cycle, held until next step
//   key_held    out  1            high while the key is considered pressed
//   step_count  out  COUNT_WIDTH  accepted presses, modulo 2**COUNT_WIDTH
module key_step_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 20,
  parameter int COUNT_WIDTH     = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   key_n,
  input  logic                   sw_w,
  output logic                   step,
  output logic                   w_out,
  output logic                   key_held,
  output logic [COUNT_WIDTH-1:0] step_count
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0]   CNT_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

  state_t                 state, state_nxt;
  logic [CNT_WIDTH-1:0]   cnt, cnt_nxt;
  logic                   key_p0, key_p1;
  logic                   w_p0, w_p1;
  logic                   step_nxt;
  logic                   w_out_nxt;
  logic                   key_held_nxt;
  logic [COUNT_WIDTH-1:0] step_count_nxt;

  // Stage p0/p1: two-FF synchronizers. The key chain resets to 1 so a reset
  // never looks like a press; a key held through reset is re-debounced.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_p0 <= 1'b1;
      key_p1 <= 1'b1;
      w_p0   <= 1'b0;
      w_p1   <= 1'b0;
    end else begin
      key_p0 <= key_n;
      key_p1 <= key_p0;
      w_p0   <= sw_w;
      w_p1   <= w_p0;
    end
  end

  // Stage p2: debounce FSM state and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      step       <= 1'b0;
      w_out      <= 1'b0;
      key_held   <= 1'b0;
      step_count <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      step       <= step_nxt;
      w_out      <= w_out_nxt;
      key_held   <= key_held_nxt;
      step_count <= step_count_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    step_nxt       = 1'b0;
    w_out_nxt      = w_out;
    step_count_nxt = step_count;

    unique case (state)
      IDLE: begin
        if (!key_p1) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (key_p1) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          // The only place a step is generated: once per IDLE->PRESSED pass.
          state_nxt      = PRESSED;
          step_nxt       = 1'b1;
          w_out_nxt      = w_p1;
          step_count_nxt = step_count + COUNT_ONE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (key_p1) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!key_p1) begin
          // Release bounce: back to PRESSED without issuing another step.
          state_nxt = PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    key_held_nxt = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
  end

endmodule

// File: tb/tb_key_step_conditioner.sv
// tb_key_step_conditioner
//   Directed bench for key_step_conditioner with DEBOUNCE_CYCLES=4. Inputs
//   are driven 1 time unit after each rising edge; outputs are sampled at
//   the same point, so "after edge N" means the value registered on edge N.
module tb_key_step_conditioner;

  localparam int DEB = 4;
  localparam int CW  = 3;
  localparam int SCW = 8;

  logic           clock = 1'b0;
  logic           reset;
  logic           key_n;
  logic           sw_w;
  logic           step;
  logic           w_out;
  logic           key_held;
  logic [SCW-1:0] step_count;

  int ncmp   = 0;
  int nerr   = 0;
  int nsteps = 0;

  key_step_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_WIDTH      (CW),
    .COUNT_WIDTH    (SCW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .key_n     (key_n),
    .sw_w      (sw_w),
    .step      (step),
    .w_out     (w_out),
    .key_held  (key_held),
    .step_count(step_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge; also tallies step pulses seen.
  task automatic tick();
    @(posedge clock);
    #1;
    if (step === 1'b1) nsteps++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Clean press: key and switch change together, held 8 edges, released 8 edges.
  task automatic press(input logic w);
    sw_w  = w;
    key_n = 1'b0;
    ticks(8);
    key_n = 1'b1;
    ticks(8);
  endtask

  initial begin
    reset = 1'b1;
    key_n = 1'b1;
    sw_w  = 1'b0;
    ticks(3);
    chk("rst_step",     step,       0);
    chk("rst_w_out",    w_out,      0);
    chk("rst_key_held", key_held,   0);
    chk("rst_count",    step_count, 0);

    // Get outputs nonzero, then assert reset between edges.
    reset = 1'b0;
    sw_w  = 1'b1;
    key_n = 1'b0;
    ticks(10);
    chk("pre_count",    step_count, 1);
    chk("pre_key_held", key_held,   1);
    #3;
    reset = 1'b1;
    #1;
    chk("async_step",     step,       0);
    chk("async_w_out",    w_out,      0);
    chk("async_key_held", key_held,   0);
    chk("async_count",    step_count, 0);
    key_n = 1'b1;
    sw_w  = 1'b0;
    ticks(2);
    reset  = 1'b0;
    nsteps = 0;
    ticks(20);
    chk("idle_nsteps", nsteps,     0);
    chk("idle_count",  step_count, 0);

    // Short glitch: 3 cycles low is under the debounce window.
    nsteps = 0;
    key_n  = 1'b0;
    ticks(3);
    key_n = 1'b1;
    ticks(12);
    chk("glitch_nsteps", nsteps,     0);
    chk("glitch_count",  step_count, 0);

    // Clean press: step appears on edge 7 after key_n goes low.
    sw_w = 1'b1;
    ticks(2);
    nsteps = 0;
    key_n  = 1'b0;
    ticks(6);
    chk("lat_early_nsteps", nsteps, 0);
    tick();
    chk("lat_step",     step,       1);
    chk("lat_w_out",    w_out,      1);
    chk("lat_count",    step_count, 1);
    chk("lat_key_held", key_held,   1);
    tick();
    chk("lat_step_clear", step, 0);
    key_n = 1'b1;
    ticks(4);
    chk("rel_wait_held", key_held, 1);
    ticks(6);
    chk("rel_key_held", key_held, 0);
    chk("rel_nsteps",   nsteps,   1);

    // Release bounce while pressed: no second step.
    nsteps = 0;
    key_n  = 1'b0;
    ticks(10);
    key_n = 1'b1;
    ticks(2);
    key_n = 1'b0;
    ticks(12);
    chk("bounce_nsteps",   nsteps,     1);
    chk("bounce_key_held", key_held,   1);
    chk("bounce_count",    step_count, 2);
    key_n = 1'b1;
    ticks(10);
    chk("bounce_rel_held", key_held, 0);

    // 256 presses from zero wrap step_count back to 0.
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    nsteps = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == 100) begin
        sw_w  = 1'b1;
        key_n = 1'b0;
        ticks(8);
        chk("wcap_w_out", w_out, 1);
        sw_w  = 1'b0;
        key_n = 1'b1;
        ticks(8);
        chk("wcap_hold_w_out", w_out, 1);
      end else if (i == 101) begin
        press(1'b0);
        chk("wcap_next_w_out", w_out, 0);
      end else begin
        press(1'b0);
      end
      if (i == 254) chk("wrap_count_255", step_count, 255);
    end
    chk("wrap_count_0", step_count, 0);
    chk("wrap_nsteps",  nsteps,     256);

    // Key held through reset: re-debounced, one step on edge 7 after release.
    key_n = 1'b0;
    #3;
    reset = 1'b1;
    ticks(3);
    reset  = 1'b0;
    nsteps = 0;
    ticks(6);
    chk("hold_rst_early", nsteps, 0);
    tick();
    chk("hold_rst_step",  step,       1);
    chk("hold_rst_count", step_count, 1);
    ticks(10);
    chk("hold_rst_nsteps", nsteps, 1);
    key_n = 1'b1;
    ticks(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
